// File: rtl/ghash_ctrl.sv
// GHASH accumulator controller: folds each 128-bit block into Y via an external
// GF(2^128) multiplier (one multiply in flight) and emits the tag on the last block.
module ghash_ctrl #(
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             h_load_i,
  input  logic [WIDTH-1:0] h_i,
  input  logic             blk_valid_i,
  input  logic [WIDTH-1:0] blk_i,
  input  logic             blk_last_i,
  output logic             blk_ready_o,
  output logic             mul_valid_o,
  output logic [WIDTH-1:0] mul_a_o,
  output logic [WIDTH-1:0] mul_b_o,
  input  logic             mul_valid_i,
  input  logic [WIDTH-1:0] mul_result_i,
  output logic             tag_valid_o,
  output logic [WIDTH-1:0] tag_o,
  output logic             err_o
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] h_q;
  logic             last_q;

  // Ready depends on state only, never on blk_valid_i.
  always_comb begin
    blk_ready_o = (state == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      y_q         <= '0;
      h_q         <= '0;
      last_q      <= 1'b0;
      mul_valid_o <= 1'b0;
      mul_a_o     <= '0;
      mul_b_o     <= '0;
      tag_valid_o <= 1'b0;
      tag_o       <= '0;
      err_o       <= 1'b0;
    end else begin
      tag_valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          // A result with no request outstanding is a protocol error; data is dropped.
          if (mul_valid_i) err_o <= 1'b1;
          if (h_load_i) h_q <= h_i;
          // Same-cycle H load and handshake: this block uses the old H.
          if (blk_valid_i) begin
            mul_a_o     <= y_q ^ blk_i;
            mul_b_o     <= h_q;
            mul_valid_o <= 1'b1;
            last_q      <= blk_last_i;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          mul_valid_o <= 1'b0;
          if (mul_valid_i) begin
            if (last_q) begin
              tag_o       <= mul_result_i;
              tag_valid_o <= 1'b1;
              y_q         <= '0;
            end else begin
              y_q <= mul_result_i;
            end
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ghash_ctrl.sv
// Scoreboard bench for ghash_ctrl with a behavioural fixed-latency GF(2^128) multiplier.
module tb_ghash_ctrl;
  localparam int unsigned WIDTH = 128;
  localparam int unsigned LAT   = 3;

  localparam logic [127:0] H2   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] C2   = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] L2   = 128'h00000000000000000000000000000080;
  localparam logic [127:0] TAG2 = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
  localparam logic [127:0] ONE  = 128'h80000000000000000000000000000000;
  localparam logic [127:0] XID  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] XID2 = 128'h00112233445566778899aabbccddeeff;

  logic             clk = 1'b0;
  logic             rst;
  logic             h_load_i;
  logic [WIDTH-1:0] h_i;
  logic             blk_valid_i;
  logic [WIDTH-1:0] blk_i;
  logic             blk_last_i;
  logic             blk_ready_o;
  logic             mul_valid_o;
  logic [WIDTH-1:0] mul_a_o;
  logic [WIDTH-1:0] mul_b_o;
  logic             mul_valid_i;
  logic [WIDTH-1:0] mul_result_i;
  logic             tag_valid_o;
  logic [WIDTH-1:0] tag_o;
  logic             err_o;

  always #5 clk = ~clk;

  ghash_ctrl #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .h_load_i     (h_load_i),
    .h_i          (h_i),
    .blk_valid_i  (blk_valid_i),
    .blk_i        (blk_i),
    .blk_last_i   (blk_last_i),
    .blk_ready_o  (blk_ready_o),
    .mul_valid_o  (mul_valid_o),
    .mul_a_o      (mul_a_o),
    .mul_b_o      (mul_b_o),
    .mul_valid_i  (mul_valid_i),
    .mul_result_i (mul_result_i),
    .tag_valid_o  (tag_valid_o),
    .tag_o        (tag_o),
    .err_o        (err_o)
  );

  // GCM bit order: bit 127 of the vector is the coefficient of x^0.
  function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z;
    logic [127:0] v;
    z = '0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      if (v[0]) v = (v >> 1) ^ {8'he1, 120'h0};
      else      v = v >> 1;
    end
    return z;
  endfunction

  logic [LAT-1:0] pipe_v;
  logic [127:0]   pipe_d [0:LAT-1];
  logic           inj_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
    end else begin
      pipe_v    <= {pipe_v[LAT-2:0], mul_valid_o};
      pipe_d[0] <= gf_mul(mul_a_o, mul_b_o);
      for (int i = 1; i < int'(LAT); i++) pipe_d[i] <= pipe_d[i-1];
    end
  end

  assign mul_valid_i  = pipe_v[LAT-1] | inj_valid;
  assign mul_result_i = pipe_d[LAT-1];

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] exp_q[$];
  int tags_seen = 0;
  int mv_high = 0;
  int low_run = 0;
  int runs[$];

  // Scoreboard monitor: every tag pulse pops one expected tag.
  always @(negedge clk) begin
    if (!rst) begin
      if (tag_valid_o) begin
        tags_seen++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_tag: got %h, no tag expected", tag_o);
        end else begin
          logic [127:0] e;
          e = exp_q.pop_front();
          if (tag_o !== e) begin
            n_err++;
            $display("FAIL tag: got %h expected %h", tag_o, e);
          end
        end
      end
      if (mul_valid_o) mv_high++;
      if (!blk_ready_o) low_run++;
      else if (low_run != 0) begin
        runs.push_back(low_run);
        low_run = 0;
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic load_h(input logic [127:0] h);
    h_load_i = 1'b1;
    h_i      = h;
    tick();
    h_load_i = 1'b0;
  endtask

  // Offers a block until accepted; returns #1 after the handshake edge.
  task automatic send(input logic [127:0] x, input logic last, input bit has_tag,
                      input logic [127:0] tag, input bit hold);
    int k;
    blk_valid_i = 1'b1;
    blk_i       = x;
    blk_last_i  = last;
    k = 0;
    while (!blk_ready_o && k < 50) begin
      tick();
      k++;
    end
    check("handshake_timeout", 128'(k < 50), 128'd1);
    if (has_tag) exp_q.push_back(tag);
    tick();
    if (!hold) blk_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || !blk_ready_o) && k < 60) begin
      tick();
      k++;
    end
    check("done_timeout", 128'(k < 60), 128'd1);
    tick();
    tick();
  endtask

  initial begin
    int t0;
    rst = 1'b1; h_load_i = 1'b0; h_i = '0; blk_valid_i = 1'b0; blk_i = '0;
    blk_last_i = 1'b0; inj_valid = 1'b0;

    // 1. reset values and sticky error
    do_reset();
    check("rst_ready", 128'(blk_ready_o), 128'd1);
    check("rst_mul_valid", 128'(mul_valid_o), 128'd0);
    check("rst_tag_valid", 128'(tag_valid_o), 128'd0);
    check("rst_err", 128'(err_o), 128'd0);
    check("rst_tag", tag_o, '0);
    check("rst_mul_a", mul_a_o, '0);
    check("rst_mul_b", mul_b_o, '0);
    inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    check("err_set", 128'(err_o), 128'd1);
    repeat (5) tick();
    check("err_sticky", 128'(err_o), 128'd1);
    do_reset();
    check("err_cleared", 128'(err_o), 128'd0);

    // 2. GCM test case 2
    t0 = tags_seen;
    load_h(H2);
    send(C2, 1'b0, 1'b0, '0, 1'b0);
    check("mul_b_is_h", mul_b_o, H2);
    check("mul_a_first", mul_a_o, C2);
    send(L2, 1'b1, 1'b1, TAG2, 1'b0);
    wait_done();
    check("case2_one_pulse", 128'(tags_seen - t0), 128'd1);

    // 3. identity and zero
    load_h(ONE);
    send(XID, 1'b1, 1'b1, XID, 1'b0);
    wait_done();
    load_h('0);
    send(128'hdeadbeefcafef00d0123456789abcdef, 1'b1, 1'b1, '0, 1'b0);
    wait_done();

    // 4. backpressure with valid held high
    load_h(H2);
    mv_high = 0;
    runs.delete();
    send(C2, 1'b0, 1'b0, '0, 1'b1);
    send(L2, 1'b1, 1'b1, TAG2, 1'b0);
    wait_done();
    check("bp_mul_valid_cycles", 128'(mv_high), 128'd2);
    check("bp_run_count", 128'(runs.size()), 128'd2);
    for (int i = 0; i < runs.size(); i++)
      check("bp_ready_low", 128'(runs[i]), 128'(LAT + 1));

    // 5a. H load during WAIT is ignored
    load_h(ONE);
    send(XID, 1'b1, 1'b1, XID, 1'b0);
    h_load_i = 1'b1;
    h_i      = '0;
    tick();
    h_load_i = 1'b0;
    wait_done();
    send(XID2, 1'b1, 1'b1, XID2, 1'b0);
    check("h_kept", mul_b_o, ONE);
    wait_done();

    // 5b. back-to-back messages
    load_h(H2);
    send(C2, 1'b0, 1'b0, '0, 1'b0);
    send(L2, 1'b1, 1'b1, TAG2, 1'b0);
    send(C2, 1'b0, 1'b0, '0, 1'b0);
    check("chain_y_cleared", mul_a_o, C2);
    send(L2, 1'b1, 1'b1, TAG2, 1'b0);
    wait_done();

    // 6. reset mid-operation
    load_h(H2);
    send(C2, 1'b0, 1'b0, '0, 1'b0);
    tick();
    do_reset();
    check("midrst_err", 128'(err_o), 128'd0);
    check("midrst_ready", 128'(blk_ready_o), 128'd1);
    check("midrst_tag", tag_o, '0);
    repeat (8) tick();
    check("midrst_err_late", 128'(err_o), 128'd0);
    load_h(H2);
    send(C2, 1'b0, 1'b0, '0, 1'b0);
    send(L2, 1'b1, 1'b1, TAG2, 1'b0);
    wait_done();

    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ghash_ctrl.md
# ghash_ctrl

GHASH accumulator controller for the AES-GCM datapath: it drives the `gf128_mul` multiplier as its requester. It accepts a stream of 128-bit blocks (AAD, ciphertext, length block), forms `Y_i = (Y_{i-1} ^ X_i) * H` using the multiplier's `valid_i/a_i/b_i` → `valid_o/result_o` interface, and emits the final tag on the last block. It allows only one multiply outstanding at a time, because each step depends on the previous one.

## Interface
- `WIDTH`, 128: block width; only 128 is supported.
- `clk`  in  1  clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `h_load_i`  in  1  load the hash subkey; honoured only in IDLE.
- `h_i`  in  WIDTH  hash subkey H, in GCM bit order (bit 127 = x^0).
- `blk_valid_i`  in  1  block offered.
- `blk_i`  in  WIDTH  block X_i.
- `blk_last_i`  in  1  marks X_i as the final block of the message.
- `blk_ready_o`  out  1  block can be accepted this cycle.
- `mul_valid_o`  out  1  multiply request; drives the multiplier's `valid_i`.
- `mul_a_o`  out  WIDTH  `Y ^ X`; drives `a_i`.
- `mul_b_o`  out  WIDTH  H; drives `b_i`.
- `mul_valid_i`  in  1  from the multiplier's `valid_o`.
- `mul_result_i`  in  WIDTH  from the multiplier's `result_o`.
- `tag_valid_o`  out  1  one-cycle pulse: the tag is valid.
- `tag_o`  out  WIDTH  final GHASH value.
- `err_o`  out  1  sticky flag: a multiplier result arrived outside WAIT.

## Operation
- **Registers:** `Y` (accumulator), `H`, `last_q`, `state`.
- **States:** IDLE, WAIT.

**IDLE**
- `blk_ready_o = 1`.
- `h_load_i` writes `H <= h_i`.
- On `blk_valid_i && blk_ready_o`:
  - register `mul_a_o <= Y ^ blk_i`, `mul_b_o <= H`, `mul_valid_o <= 1`;
  - set `last_q <= blk_last_i`;
  - go to WAIT.
- If `h_load_i` and a handshake occur in the same cycle, the block is multiplied by the old H. The new H is written that cycle and applies from the next block onward.

**WAIT**
- `blk_ready_o = 0`.
- `h_load_i` is ignored.
- `mul_valid_o` is high for exactly the first WAIT cycle, then 0. `mul_a_o` and `mul_b_o` hold their values.
- On `mul_valid_i`:
  - if `!last_q`: `Y <= mul_result_i`;
  - if `last_q`: `tag_o <= mul_result_i`, `tag_valid_o <= 1` next cycle, and `Y <= 0` (ready for the next message);
  - in both cases go to IDLE.

**Errors and unsupported inputs**
- `mul_valid_i` in IDLE: ignored for data, `err_o <= 1`. Only reset clears `err_o`.
- Empty message (no blocks) is not supported; no tag is produced.
- XOR is bitwise; there is no carry or width growth. All reduction is done inside the multiplier.

## Timing
- **Reset values** (synchronous `rst`, which has priority over everything):
  - state IDLE; `Y`, `H`, `last_q` = 0;
  - `mul_valid_o`, `tag_valid_o`, `err_o` = 0;
  - `mul_a_o`, `mul_b_o`, `tag_o` = 0;
  - `blk_ready_o` = 1 in the cycle after `rst` deasserts.
- **Handshake:**
  - handshake at edge t → `mul_valid_o` high in cycle t+1;
  - the multiplier (latency L) asserts `mul_valid_i` in cycle t+1+L;
  - `tag_valid_o`/`tag_o` are registered and appear in cycle t+2+L;
  - `blk_ready_o` is 1 again in cycle t+2+L.
- **Throughput:** one block per L+2 cycles.
- `blk_ready_o` is a combinational decode of state only; it does not depend on `blk_valid_i`.
- **Reset mid-operation:** the in-flight multiply is abandoned. The multiplier must be reset alongside this block; otherwise its stale result sets `err_o`.
- `tag_valid_o` is a single-cycle pulse. `tag_o` holds its value until the next tag or reset.

## Test plan
1. **Reset:** hold `rst` for 2 cycles → all outputs 0 and `blk_ready_o = 1` after release. A `mul_valid_i` pulse in IDLE → `err_o = 1`, and it stays 1 until reset.
2. **GCM test case 2:**
   - load `H = 66e94bd4ef8a2c3b884cfa59ca342b2e`;
   - send `0388dace60b6a392f328c2b971b2fe78`, then `00000000000000000000000000000080` with last;
   - expect `tag_o = f38cbb1ad69223dcc3457ae5b6b0f885` with exactly one `tag_valid_o` pulse.
3. **Identity and zero:**
   - `H = 8000…0` (the GF element 1), single last block `X = 0123456789abcdeffedcba9876543210` → `tag_o = X`;
   - then `H = 0`, any block → `tag_o = 0`.
4. **Backpressure:** hold `blk_valid_i` high continuously across the case-2 stream. Expect:
   - exactly two `mul_valid_o` pulses, each one cycle wide;
   - `blk_ready_o` low for L+1 cycles after each handshake;
   - the same tag as case 2.
5. **H-load races and message chaining:**
   - assert `h_load_i` in WAIT → H is unchanged and the result matches the old H;
   - two back-to-back case-2 messages → both tags equal `f38cbb1ad69223dcc3457ae5b6b0f885` (`Y` is cleared between messages).
6. **Reset mid-operation:** assert `rst` in WAIT, with the multiplier also reset → no tag, `err_o = 0`, and a fresh case-2 run passes.
